// File: rtl/cva6_fifo_pkg.sv
// rtl/cva6_fifo_pkg.sv - shared types for the cva6 FIFO stream-out stage
package cva6_fifo_pkg;

    // Occupancy of the two-entry skid buffer behind the FIFO.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } stream_out_state_e;

    // True while the skid buffer can still take one more word from the FIFO.
    function automatic logic stream_out_has_room(input stream_out_state_e state);
        return state != TWO;
    endfunction

endpackage

// File: rtl/cva6_sat_counter.sv
// rtl/cva6_sat_counter.sv - saturating up-counter with synchronous clear
module cva6_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;
    assign cnt_o = r_cnt;

    // Clear beats increment; the count sticks at all-ones once reached.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_sat) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cva6_fifo_stream_out.sv
// rtl/cva6_fifo_stream_out.sv - FIFO empty/pop view to registered valid/ready stream
module cva6_fifo_stream_out
    import cva6_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    input  logic                  stall_clr_i,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    stream_out_state_e     r_state;
    stream_out_state_e     w_state_next;
    logic [DATA_WIDTH-1:0] r_slot0;
    logic [DATA_WIDTH-1:0] r_slot1;
    logic [DATA_WIDTH-1:0] w_slot0_next;
    logic [DATA_WIDTH-1:0] w_slot1_next;
    logic                  w_pop;
    logic                  w_acc;
    logic                  w_stall;

    // Pop decision looks only at FIFO status and our own occupancy, never at
    // ready_i, so the consumer's ready path stops at this stage's registers.
    assign w_pop      = rst_ni & ~fifo_empty_i & ~flush_i & stream_out_has_room(r_state);
    assign fifo_pop_o = w_pop;

    assign valid_o = (r_state != EMPTY);
    assign data_o  = r_slot0;
    assign w_acc   = valid_o & ready_i;
    assign w_stall = valid_o & ~ready_i;

    // Next occupancy and slot contents; slot0 is always the head of the stream.
    always_comb begin
        w_state_next = r_state;
        w_slot0_next = r_slot0;
        w_slot1_next = r_slot1;
        if (flush_i) begin
            w_state_next = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_pop) begin
                        w_state_next = ONE;
                        w_slot0_next = fifo_data_i;
                    end
                end
                ONE: begin
                    if (w_pop && w_acc) begin
                        w_slot0_next = fifo_data_i;
                    end else if (w_pop) begin
                        w_state_next = TWO;
                        w_slot1_next = fifo_data_i;
                    end else if (w_acc) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_acc) begin
                        w_state_next = ONE;
                        w_slot0_next = r_slot1;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // Occupancy and slot registers; reset drops any buffered words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= EMPTY;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_state <= w_state_next;
            r_slot0 <= w_slot0_next;
            r_slot1 <= w_slot1_next;
        end
    end

    // Backpressure cycles; a flush restarts the count along with the stream.
    cva6_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_stall),
        .clr_i  (stall_clr_i | flush_i),
        .cnt_o  (stall_cnt_o)
    );

    a_pop_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_pop_o |-> !fifo_empty_i);

    a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> $stable(data_o));

    a_no_pop_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((r_state == TWO) && fifo_pop_o));

endmodule

// File: tb/tb_cva6_fifo_stream_out.sv
// tb/tb_cva6_fifo_stream_out.sv - self-checking bench for cva6_fifo_stream_out
module tb_cva6_fifo_stream_out;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        flush_i      = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [31:0] fifo_data_i  = '0;
    logic        ready_i      = 1'b0;
    logic        stall_clr_i  = 1'b0;

    logic        fifo_pop_o, valid_o;
    logic [31:0] data_o;
    logic [15:0] stall_cnt_o;
    logic        fifo_pop4, valid4;
    logic [31:0] data4;
    logic [3:0]  stall_cnt4;

    cva6_fifo_stream_out #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .stall_clr_i  (stall_clr_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    cva6_fifo_stream_out #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop4),
        .valid_o      (valid4),
        .data_o       (data4),
        .ready_i      (ready_i),
        .stall_clr_i  (stall_clr_i),
        .stall_cnt_o  (stall_cnt4)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          dut_pops = 0;
    logic [31:0] src_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] out_q[$];
    int          acc_cyc_q[$];
    int unsigned m_cnt16  = 0;
    int unsigned m_cnt4   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic fl, input logic clr);
        ready_i      = rdy;
        flush_i      = fl;
        stall_clr_i  = clr;
        fifo_empty_i = (src_q.size() == 0);
        fifo_data_i  = (src_q.size() != 0) ? src_q[0] : 32'h0;
    endtask

    task automatic check_outputs();
        logic exp_valid;
        logic exp_pop;
        exp_valid = (buf_q.size() != 0);
        exp_pop   = rst_ni && (src_q.size() != 0) && !flush_i && (buf_q.size() < 2);
        check("valid_o", valid_o, exp_valid);
        check("valid_o_w4", valid4, exp_valid);
        if (exp_valid) begin
            check("data_o", data_o, buf_q[0]);
            check("data_o_w4", data4, buf_q[0]);
        end
        check("fifo_pop_o", fifo_pop_o, exp_pop);
        check("fifo_pop_o_w4", fifo_pop4, exp_pop);
        check("stall_cnt16", stall_cnt_o, m_cnt16);
        check("stall_cnt4", stall_cnt4, m_cnt4);
    endtask

    // Reference: the stage is a queue of at most two words fed from the FIFO.
    task automatic model_advance();
        logic v, acc, pop;
        v   = (buf_q.size() != 0);
        acc = v && ready_i;
        pop = (src_q.size() != 0) && !flush_i && (buf_q.size() < 2);
        if (stall_clr_i || flush_i) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else if (v && !ready_i) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush_i) begin
            buf_q.delete();
            src_q.delete();
        end else begin
            if (acc) void'(buf_q.pop_front());
            if (pop) buf_q.push_back(src_q.pop_front());
        end
    endtask

    task automatic step(input logic rdy, input logic fl, input logic clr);
        drive(rdy, fl, clr);
        #1;
        check_outputs();
        if (fifo_pop_o) dut_pops++;
        if (valid_o && ready_i) begin
            out_q.push_back(data_o);
            acc_cyc_q.push_back(cyc);
        end
        model_advance();
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        src_q.delete();
        src_q.push_back(32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, 32'h0);
        check("rst_cnt", stall_cnt_o, 16'h0);
        check("rst_pop", fifo_pop_o, 1'b0);
        src_q.delete();
        buf_q.delete();
        out_q.delete();
        acc_cyc_q.delete();
        m_cnt16  = 0;
        m_cnt4   = 0;
        dut_pops = 0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;

        // Three words, consumer always ready: back-to-back delivery.
        do_reset();
        src_q = '{32'hA, 32'hB, 32'hC};
        repeat (6) step(1'b1, 1'b0, 1'b0);
        check("t1_count", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("t1_w0", out_q[0], 32'hA);
            check("t1_w1", out_q[1], 32'hB);
            check("t1_w2", out_q[2], 32'hC);
            check("t1_no_bubble", acc_cyc_q[2] - acc_cyc_q[0], 2);
            check("t1_first_cyc", acc_cyc_q[0], 1);
        end
        check("t1_pops", dut_pops, 3);

        // Backpressure for five cycles: two words buffered, head held.
        do_reset();
        src_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("t2_pops", dut_pops, 2);
        check("t2_stall", stall_cnt_o, 16'd4);
        check("t2_head", data_o, 32'hA);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        check("t2_count", out_q.size(), 4);
        if (out_q.size() == 4)
            for (int i = 0; i < 4; i++) check("t2_order", out_q[i], 32'hA + i);

        // Alternating ready with a deep FIFO: order preserved.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = 32'h1000_0000 + i * 32'h0101;
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        for (int i = 0; i < 40; i++) step(logic'(i % 2 == 0), 1'b0, 1'b0);
        check("t3_count", out_q.size(), 16);
        if (out_q.size() == 16)
            for (int i = 0; i < 16; i++) check("t3_order", out_q[i], exp_q[i]);

        // Flush while full, then a fresh word two cycles later.
        do_reset();
        src_q = '{32'h1, 32'h2, 32'h3};
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("t4_valid", valid_o, 1'b0);
        check("t4_cnt", stall_cnt_o, 16'h0);
        src_q.push_back(32'h55);
        step(1'b1, 1'b0, 1'b0);
        check("t4_new_valid", valid_o, 1'b1);
        check("t4_new_data", data_o, 32'h55);
        step(1'b1, 1'b0, 1'b0);

        // Long stall: narrow counter saturates, clear wins over increment.
        do_reset();
        src_q = '{32'h9};
        repeat (21) step(1'b0, 1'b0, 1'b0);
        check("t5_sat4", stall_cnt4, 4'hF);
        check("t5_cnt16", stall_cnt_o, 16'd20);
        step(1'b0, 1'b0, 1'b1);
        check("t5_clr4", stall_cnt4, 4'h0);
        check("t5_clr16", stall_cnt_o, 16'h0);

        // Asynchronous reset in the middle of a cycle while holding a word.
        do_reset();
        src_q = '{32'h77};
        repeat (3) step(1'b0, 1'b0, 1'b0);
        src_q.push_back(32'h88);
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_valid", valid_o, 1'b0);
        check("t6_data", data_o, 32'h0);
        check("t6_cnt", stall_cnt_o, 16'h0);
        check("t6_cnt4", stall_cnt4, 4'h0);
        check("t6_pop", fifo_pop_o, 1'b0);
        do_reset();

        // Random traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            if (($urandom % 3 != 0) && (src_q.size() < 6)) src_q.push_back($urandom);
            step(logic'($urandom % 4 != 0 ? ($urandom % 2) : 1),
                 logic'($urandom % 40 == 0),
                 logic'($urandom % 25 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
